// File: rtl/ddc2.sv
// ddc2: NCO + CORDIC mixer feeding a two-stage integrate-and-dump CIC decimator.
// Define DDC2_OVERRUN_EN to build the sticky overrun flag; otherwise overrun reads 0.
module ddc2 #(
  parameter int BW = 16,
  parameter int ZW = 16,
  parameter int RW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [RW-1:0] rate1,
  input  logic [RW-1:0] rate2,
  input  logic [31:0]   freq,
  input  logic [31:0]   phase_offset,
  input  logic          phase_load,
  input  logic          bypass,
  input  logic [BW-1:0] i_in,
  input  logic [BW-1:0] q_in,
  output logic [BW-1:0] i_out,
  output logic [BW-1:0] q_out,
  output logic          strobe,
  output logic          out_valid,
  input  logic          out_ack,
  output logic          overrun,
  input  logic          overrun_clr,
  output logic [15:0]   sample_count
);
  localparam int AW     = BW + RW;
  localparam int CW     = BW + 2;
  localparam int STAGES = (ZW < 16) ? ZW : 16;
  // atan(2^-k) in units of 2^32 per turn
  localparam logic [31:0] ATAN [16] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D};

  function automatic int blen(input logic [RW-1:0] r);
    int n;
    n = 1;
    for (int k = 0; k < RW; k++) if (r[k]) n = k + 1;
    return n;
  endfunction

  function automatic logic signed [BW-1:0] dump(input logic signed [AW-1:0] s, input int sh);
    logic signed [AW-1:0] t;
    t = s >>> sh;
    return t[BW-1:0];
  endfunction

  // CORDIC gain (~1.647) scaled by 1/4 so a full-scale complex input cannot wrap
  function automatic logic signed [BW-1:0] cnorm(input logic signed [CW-1:0] v);
    logic signed [CW-1:0] t;
    t = v >>> 2;
    return t[BW-1:0];
  endfunction

  logic [31:0]   phase;
  logic [RW-1:0] ctr1, ctr2;
  logic          strobe1, strobe2;

  assign strobe2 = reset & enable & (ctr2 == rate2);
  assign strobe1 = strobe2 & (ctr1 == rate1);
  assign strobe  = strobe1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctr1 <= '0;
      ctr2 <= '0;
    end else if (!enable) begin
      ctr1 <= '0;
      ctr2 <= '0;
    end else begin
      ctr2 <= strobe2 ? '0 : ctr2 + 1'b1;
      if (strobe2) ctr1 <= strobe1 ? '0 : ctr1 + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          phase <= '0;
    else if (phase_load) phase <= phase_offset;
    else if (enable)     phase <= phase + freq;
  end

  logic signed [CW-1:0] cx [0:STAGES];
  logic signed [CW-1:0] cy [0:STAGES];
  logic signed [ZW-1:0] cz [0:STAGES];
  logic signed [ZW-1:0] z0;
  logic signed [CW-1:0] xi, yq;
  logic                 flip;

  // rotate by -phase; angles beyond +-90 deg get a 180 deg pre-rotation
  always_comb begin
    z0   = -phase[31 -: ZW];
    flip = z0[ZW-1] ^ z0[ZW-2];
    xi   = CW'($signed(i_in));
    yq   = CW'($signed(q_in));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        cx[k] <= '0;
        cy[k] <= '0;
        cz[k] <= '0;
      end
    end else begin
      cx[0] <= flip ? -xi : xi;
      cy[0] <= flip ? -yq : yq;
      cz[0] <= flip ? {~z0[ZW-1], z0[ZW-2:0]} : z0;
      for (int k = 0; k < STAGES; k++) begin
        if (cz[k][ZW-1]) begin
          cx[k+1] <= cx[k] + (cy[k] >>> k);
          cy[k+1] <= cy[k] - (cx[k] >>> k);
          cz[k+1] <= cz[k] + ZW'(ATAN[k] >> (32 - ZW));
        end else begin
          cx[k+1] <= cx[k] - (cy[k] >>> k);
          cy[k+1] <= cy[k] + (cx[k] >>> k);
          cz[k+1] <= cz[k] - ZW'(ATAN[k] >> (32 - ZW));
        end
      end
    end
  end

  logic signed [BW-1:0] byp_i, byp_q, x_i, x_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byp_i <= '0;
      byp_q <= '0;
    end else begin
      byp_i <= i_in;
      byp_q <= q_in;
    end
  end

  assign x_i = bypass ? byp_i : cnorm(cx[STAGES]);
  assign x_q = bypass ? byp_q : cnorm(cy[STAGES]);

  logic signed [AW-1:0] acc1_i, acc1_q, acc2_i, acc2_q;
  logic signed [AW-1:0] sum1_i, sum1_q, sum2_i, sum2_q;
  logic signed [BW-1:0] s1_i, s1_q, o_i, o_q;

  always_comb begin
    sum1_i = acc1_i + AW'(x_i);
    sum1_q = acc1_q + AW'(x_q);
    s1_i   = dump(sum1_i, blen(rate2));
    s1_q   = dump(sum1_q, blen(rate2));
    sum2_i = acc2_i + AW'(s1_i);
    sum2_q = acc2_q + AW'(s1_q);
    o_i    = dump(sum2_i, blen(rate1));
    o_q    = dump(sum2_q, blen(rate1));
  end

  // partial sums are dropped whenever the counters restart
  always_ff @(posedge clock or negedge reset) begin
    if (!reset || !enable) begin
      acc1_i <= '0;
      acc1_q <= '0;
      acc2_i <= '0;
      acc2_q <= '0;
    end else begin
      acc1_i <= strobe2 ? '0 : sum1_i;
      acc1_q <= strobe2 ? '0 : sum1_q;
      if (strobe2) begin
        acc2_i <= strobe1 ? '0 : sum2_i;
        acc2_q <= strobe1 ? '0 : sum2_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_out        <= '0;
      q_out        <= '0;
      out_valid    <= 1'b0;
      sample_count <= '0;
    end else begin
      if (strobe) begin
        i_out        <= o_i;
        q_out        <= o_q;
        sample_count <= sample_count + 16'd1;
      end
      if (strobe)                  out_valid <= 1'b1;
      else if (enable && out_ack)  out_valid <= 1'b0;
    end
  end

`ifdef DDC2_OVERRUN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                  overrun <= 1'b0;
    else if (strobe && out_valid && !out_ack)    overrun <= 1'b1;
    else if (enable && overrun_clr)              overrun <= 1'b0;
  end
`else
  logic unused_clr;
  assign overrun    = 1'b0;
  assign unused_clr = overrun_clr;
`endif

  logic [ZW-1:0] unused_z;
  assign unused_z = cz[STAGES];

endmodule

// File: tb/tb_ddc2.sv
// Scoreboard bench for ddc2: a window-sum model of the two decimation stages
// predicts strobe timing, handshake flags and bypass-mode output data.
module tb_ddc2;
  localparam int BW = 16;
  localparam int RW = 8;
`ifdef DDC2_OVERRUN_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0, phase_load = 1'b0, bypass = 1'b1;
  logic          out_ack = 1'b0, overrun_clr = 1'b0;
  logic [RW-1:0] rate1 = '0, rate2 = '0;
  logic [31:0]   freq = '0, phase_offset = '0;
  logic [BW-1:0] i_in = '0, q_in = '0;
  logic [BW-1:0] i_out, q_out;
  logic          strobe, out_valid, overrun;
  logic [15:0]   sample_count;

  always #5 clock = ~clock;

  ddc2 dut (
    .clock(clock), .reset(reset), .enable(enable), .rate1(rate1), .rate2(rate2),
    .freq(freq), .phase_offset(phase_offset), .phase_load(phase_load), .bypass(bypass),
    .i_in(i_in), .q_in(q_in), .i_out(i_out), .q_out(q_out), .strobe(strobe),
    .out_valid(out_valid), .out_ack(out_ack), .overrun(overrun),
    .overrun_clr(overrun_clr), .sample_count(sample_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic near(string name, longint act, longint exp, longint tol);
    total++;
    if (act > exp + tol || act < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d +-%0d", name, act, exp, tol);
    end
  endtask

  typedef struct { longint i; longint q; bit known; } exp_t;
  exp_t sbq[$];

  // reference model state
  int       n = 0;
  longint   hist_i[$], hist_q[$];
  longint   prev_i = 0, prev_q = 0, last_i = 0, last_q = 0;
  bit       last_known = 1'b1, m_vld = 1'b0, m_ov = 1'b0;
  int       m_cnt = 0;

  function automatic int shift_of(int r);
    return (r == 0) ? 1 : $clog2(r + 1);
  endfunction

  // output = (sum over stage-1 groups of (group sum >>> shift2)) >>> shift1
  task automatic cic_expect(output longint ri, output longint rq);
    int n1, n2;
    longint ti, tq, si, sq;
    n1 = int'(rate1) + 1;
    n2 = int'(rate2) + 1;
    ti = 0; tq = 0;
    for (int g = 0; g < n1; g++) begin
      si = 0; sq = 0;
      for (int j = 0; j < n2; j++) begin
        si += hist_i[g*n2 + j];
        sq += hist_q[g*n2 + j];
      end
      ti += si >>> shift_of(int'(rate2));
      tq += sq >>> shift_of(int'(rate2));
    end
    ri = ti >>> shift_of(int'(rate1));
    rq = tq >>> shift_of(int'(rate1));
  endtask

  always @(negedge clock) begin
    bit   es;
    int   p;
    exp_t e;
    if (!reset) begin
      check("rst_strobe", strobe, 0);
      check("rst_i_out", i_out, 0);
      check("rst_q_out", q_out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_sample_count", sample_count, 0);
      n = 0; hist_i.delete(); hist_q.delete();
      prev_i = 0; prev_q = 0; last_i = 0; last_q = 0; last_known = 1'b1;
      m_vld = 1'b0; m_ov = 1'b0; m_cnt = 0; sbq.delete();
    end else begin
      p  = (int'(rate1) + 1) * (int'(rate2) + 1);
      es = enable && ((n + 1) % p == 0);
      check("strobe", strobe, es);
      check("out_valid", out_valid, m_vld);
      check("overrun", overrun, m_ov);
      check("sample_count", sample_count, m_cnt);
      if (last_known) begin
        check("held_i", $signed(i_out), last_i);
        check("held_q", $signed(q_out), last_q);
      end
      if (enable) begin
        hist_i.push_back(prev_i);
        hist_q.push_back(prev_q);
        n++;
        if (es) begin
          cic_expect(e.i, e.q);
          e.known = bypass;
          sbq.push_back(e);
          last_i = e.i; last_q = e.q; last_known = bypass;
          if (OV_EN && m_vld && !out_ack) m_ov = 1'b1;
          else if (overrun_clr)           m_ov = 1'b0;
          m_vld = 1'b1;
          m_cnt = (m_cnt + 1) & 16'hFFFF;
          n = 0; hist_i.delete(); hist_q.delete();
        end else begin
          if (out_ack)     m_vld = 1'b0;
          if (overrun_clr) m_ov  = 1'b0;
        end
      end else begin
        n = 0; hist_i.delete(); hist_q.delete();
      end
      prev_i = $signed(i_in);
      prev_q = $signed(q_in);
    end
  end

  // monitor: each strobe produces one captured sample after the next edge
  always @(negedge clock) begin
    exp_t e;
    if (reset && strobe) begin
      @(posedge clock); #1;
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: strobe with no expected sample at %0t", $time);
      end else begin
        e = sbq.pop_front();
        if (e.known) begin
          check("sb_i_out", $signed(i_out), e.i);
          check("sb_q_out", $signed(q_out), e.q);
        end
      end
    end
  end

  bit rand_data = 1'b1;
  bit rand_ack  = 1'b0;

  task automatic step(int k);
    repeat (k) begin
      @(posedge clock); #1;
      if (rand_data) begin
        i_in = BW'($urandom);
        q_in = BW'($urandom);
      end
      if (rand_ack) begin
        out_ack     = ($urandom_range(0, 3) == 0);
        overrun_clr = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  task automatic cordic_case(logic [31:0] ph, longint ei, longint eq, string tag);
    enable = 1'b0; bypass = 1'b0; rand_data = 1'b0; rate1 = '0; rate2 = '0;
    freq = '0; phase_offset = ph; phase_load = 1'b1;
    i_in = 16'd8000; q_in = '0;
    step(1);
    phase_load = 1'b0; enable = 1'b1;
    step(30);
    near({tag, "_i"}, $signed(i_out), ei, 8);
    near({tag, "_q"}, $signed(q_out), eq, 8);
  endtask

  logic [31:0] pexp [4] = '{32'h50000000, 32'h90000000, 32'hD0000000, 32'h10000000};

  initial begin
    #2 reset = 1'b0;
    step(3);
    reset = 1'b1;

    // phase load works with enable low, then accumulates
    freq = 32'h40000000; phase_offset = 32'h10000000; phase_load = 1'b1;
    step(1);
    phase_load = 1'b0;
    check("phase_load", dut.phase, 32'h10000000);
    step(1);
    check("phase_hold", dut.phase, 32'h10000000);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("phase_acc", dut.phase, pexp[k]);
    end
    step(6);

    // rate2=3 rate1=1: strobes 7,15,23 cycles after enable
    enable = 1'b0; step(1);
    rate2 = 8'd3; rate1 = 8'd1; enable = 1'b1;
    step(29);
    enable = 1'b0;
    step(3);
    check("ctr2_clear", dut.ctr2, 0);
    check("ctr1_clear", dut.ctr1, 0);
    enable = 1'b1;
    step(12);

    // overrun sequence
    enable = 1'b0; out_ack = 1'b0; overrun_clr = 1'b0; rate2 = 8'd3; rate1 = 8'd0;
    step(1);
    enable = 1'b1;
    step(8);
    overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
    step(2);
    out_ack = 1'b1; step(4);
    out_ack = 1'b0; overrun_clr = 1'b1; step(4);
    overrun_clr = 1'b0; step(4);

    // async reset mid-period
    enable = 1'b0; step(1);
    rate2 = 8'd3; rate1 = 8'd1; enable = 1'b1;
    step(5);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("arst_strobe", strobe, 0);
    check("arst_i_out", i_out, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_sample_count", sample_count, 0);
    step(2);
    reset = 1'b1;
    step(20);

    // randomized runs
    rand_ack = 1'b1;
    for (int it = 0; it < 40; it++) begin
      enable = 1'b0;
      rate1 = RW'($urandom_range(0, 3));
      rate2 = RW'($urandom_range(0, 4));
      step(1);
      enable = 1'b1;
      step($urandom_range(5, 40));
    end
    rand_ack = 1'b0; out_ack = 1'b0; overrun_clr = 1'b0;

    // CORDIC mixer sanity: 8000 * 1.6468 / 4 / 2 / 2 ~= 823
    cordic_case(32'h00000000,  823,    0, "mix0");
    cordic_case(32'h40000000,    0, -823, "mix90");
    cordic_case(32'h80000000, -823,    0, "mix180");
    cordic_case(32'hC0000000,    0,  823, "mix270");

    // rate 0: strobe every cycle, sample_count wraps
    enable = 1'b0; bypass = 1'b1; rand_data = 1'b1; rand_ack = 1'b1;
    rate1 = '0; rate2 = '0;
    step(1);
    enable = 1'b1;
    step(65540);
    enable = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
